// File: rtl/hs_chan_arbiter.sv
// ---------------------------------------------------------------------------
// hs_chan_arbiter
//   Round-robin arbiter that shares one downstream 4-phase req/ack
//   bundled-data channel among N upstream 4-phase requesters. A port is
//   granted, its payload is latched and forwarded downstream, the downstream
//   handshake is completed, and then the upstream handshake is completed.
//
// Optional build macro:
//   HS_ARB_SYNC_EN - when defined, ack_dn and every req_up bit pass through a
//                    2-flop synchronizer before the FSM sees them. Each
//                    input-to-response latency grows by 2 cycles.
//
// Parameters:
//   N   number of upstream requesters (2..8)
//   DW  payload width
//   IW  grant index width, must equal $clog2(N)
//
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   req_up    per-port 4-phase request
//   ack_up    per-port 4-phase acknowledge (one-hot or zero)
//   data_up   per-port payload, port i at [i*DW +: DW]
//   req_dn    downstream request
//   ack_dn    downstream acknowledge
//   data_dn   payload forwarded downstream
//   grant_id  index of current / last granted port
//   busy      high while the FSM is not idle
// ---------------------------------------------------------------------------
module hs_chan_arbiter #(
  parameter int N  = 4,
  parameter int DW = 3,
  parameter int IW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_up,
  output logic [N-1:0]    ack_up,
  input  logic [N*DW-1:0] data_up,
  output logic            req_dn,
  input  logic            ack_dn,
  output logic [DW-1:0]   data_dn,
  output logic [IW-1:0]   grant_id,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RTZ  = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_req_dn, w_req_dn_nxt;
  logic [N-1:0]    r_ack_up, w_ack_up_nxt;
  logic [DW-1:0]   r_data_dn, w_data_nxt;
  logic [IW-1:0]   r_gid, w_gid_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;
  logic            r_busy;

  // FSM-side view of the asynchronous-capable inputs
  logic            w_ack_dn;
  logic [N-1:0]    w_req_up;

`ifdef HS_ARB_SYNC_EN
  logic [1:0]      r_ack_sync;
  logic [N-1:0]    r_req_sync0, r_req_sync1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ack_sync  <= '0;
      r_req_sync0 <= '0;
      r_req_sync1 <= '0;
    end else begin
      r_ack_sync  <= {r_ack_sync[0], ack_dn};
      r_req_sync0 <= req_up;
      r_req_sync1 <= r_req_sync0;
    end
  end

  assign w_ack_dn = r_ack_sync[1];
  assign w_req_up = r_req_sync1;
`else
  assign w_ack_dn = ack_dn;
  assign w_req_up = req_up;
`endif

  // A port still holding ack high (mid return-to-zero) may not be re-granted.
  logic [N-1:0]    w_elig;
  logic            w_any;
  logic [IW-1:0]   w_pick;

  assign w_elig = w_req_up & ~r_ack_up;

  // Scan from the round-robin pointer upward with wrap; first eligible wins.
  always_comb begin
    int t;
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = 0; k < N; k++) begin
      t = int'(r_ptr) + k;
      if (t >= N) t = t - N;
      if (!w_any && w_elig[t]) begin
        w_any  = 1'b1;
        w_pick = IW'(t);
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_req_dn_nxt = r_req_dn;
    w_ack_up_nxt = r_ack_up;
    w_data_nxt   = r_data_dn;
    w_gid_nxt    = r_gid;
    w_ptr_nxt    = r_ptr;
    case (r_state)
      IDLE: begin
        // A lingering ack from downstream blocks new grants until it drops.
        if (!w_ack_dn && w_any) begin
          w_data_nxt   = data_up[w_pick*DW +: DW];
          w_gid_nxt    = w_pick;
          w_req_dn_nxt = 1'b1;
          w_state_nxt  = SEND;
        end
      end
      SEND: begin
        // Upstream req dropping early is ignored: the transfer completes.
        if (w_ack_dn) begin
          w_req_dn_nxt        = 1'b0;
          w_ack_up_nxt        = '0;
          w_ack_up_nxt[r_gid] = 1'b1;
          w_state_nxt         = RTZ;
        end
      end
      RTZ: begin
        if (!w_ack_dn && !w_req_up[r_gid]) begin
          w_ack_up_nxt = '0;
          w_ptr_nxt    = (r_gid == IW'(N-1)) ? '0 : r_gid + 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      default: begin
        w_req_dn_nxt = 1'b0;
        w_ack_up_nxt = '0;
        w_state_nxt  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_req_dn  <= 1'b0;
      r_ack_up  <= '0;
      r_data_dn <= '0;
      r_gid     <= '0;
      r_ptr     <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_req_dn  <= w_req_dn_nxt;
      r_ack_up  <= w_ack_up_nxt;
      r_data_dn <= w_data_nxt;
      r_gid     <= w_gid_nxt;
      r_ptr     <= w_ptr_nxt;
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

  assign req_dn   = r_req_dn;
  assign ack_up   = r_ack_up;
  assign data_dn  = r_data_dn;
  assign grant_id = r_gid;
  assign busy     = r_busy;

endmodule

// File: tb/tb_hs_chan_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hs_chan_arbiter
//   Directed bench for hs_chan_arbiter (N=4, DW=3). Inputs are driven 1 time
//   unit after each rising edge and outputs are checked at that same point,
//   so every check sees the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_hs_chan_arbiter;

  localparam int N  = 4;
  localparam int DW = 3;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_up;
  logic [N-1:0]    ack_up;
  logic [N*DW-1:0] data_up;
  logic            req_dn;
  logic            ack_dn;
  logic [DW-1:0]   data_dn;
  logic [IW-1:0]   grant_id;
  logic            busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hs_chan_arbiter #(.N(N), .DW(DW), .IW(IW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_up   (req_up),
    .ack_up   (ack_up),
    .data_up  (data_up),
    .req_dn   (req_dn),
    .ack_dn   (ack_dn),
    .data_dn  (data_dn),
    .grant_id (grant_id),
    .busy     (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction starting in IDLE with port g requesting.
  // Port g re-raises its request afterwards so all ports stay pending.
  task automatic xfer(input int g, input logic [31:0] d);
    tick();
    chk("rr_gid", grant_id, g);
    chk("rr_data", data_dn, d);
    chk("rr_req_dn", req_dn, 1);
    ack_dn = 1'b1;
    tick();
    chk("rr_ack_up", ack_up, 32'd1 << g);
    chk("rr_req_dn_low", req_dn, 0);
    req_up[g] = 1'b0;
    ack_dn    = 1'b0;
    tick();
    chk("rr_ack_low", ack_up, 0);
    chk("rr_idle", busy, 0);
    req_up[g] = 1'b1;
  endtask

  initial begin
    // ---- reset with all requests high ----
    rst_n   = 1'b0;
    req_up  = 4'b1111;
    ack_dn  = 1'b0;
    data_up = {3'd4, 3'd3, 3'd2, 3'd1};
    tick();
    tick();
    chk("rst_req_dn", req_dn, 0);
    chk("rst_ack_up", ack_up, 0);
    chk("rst_data", data_dn, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy", busy, 0);
    rst_n  = 1'b1;
    req_up = 4'b0000;
    tick();
    chk("post_rst_req_dn", req_dn, 0);
    chk("post_rst_busy", busy, 0);

    // ---- single transfer on port 2 ----
    req_up      = 4'b0100;
    data_up[6 +: 3] = 3'd5;
    tick();
    chk("one_req_dn", req_dn, 1);
    chk("one_data", data_dn, 5);
    chk("one_gid", grant_id, 2);
    chk("one_busy", busy, 1);
    chk("one_ack_up0", ack_up, 0);
    data_up[6 +: 3] = 3'd7;   // late data change must be ignored
    tick();
    chk("one_data_hold", data_dn, 5);
    chk("one_req_hold", req_dn, 1);
    ack_dn = 1'b1;
    tick();
    chk("one_ack_up", ack_up, 4'b0100);
    chk("one_req_dn_low", req_dn, 0);
    chk("one_data_rtz", data_dn, 5);
    ack_dn = 1'b0;            // req still high: ack must hold
    tick();
    chk("one_ack_hold", ack_up, 4'b0100);
    chk("one_busy_rtz", busy, 1);
    req_up = 4'b0000;
    tick();
    chk("one_ack_low", ack_up, 0);
    chk("one_idle", busy, 0);

    // ---- round robin from pointer 0 ----
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    data_up = {3'd4, 3'd3, 3'd2, 3'd1};
    req_up  = 4'b1111;
    xfer(0, 1);
    xfer(1, 2);
    xfer(2, 3);
    xfer(3, 4);
    xfer(0, 1);              // pointer wrapped after port 3

    // ---- stale ack in IDLE (pointer now 1) ----
    req_up = 4'b0000;
    ack_dn = 1'b1;
    tick();
    req_up = 4'b0001;
    tick();
    chk("stale_req_dn", req_dn, 0);
    chk("stale_busy", busy, 0);
    tick();
    chk("stale_req_dn2", req_dn, 0);
    ack_dn = 1'b0;
    tick();
    chk("stale_grant_req", req_dn, 1);
    chk("stale_grant_gid", grant_id, 0);
    ack_dn = 1'b1;
    tick();
    req_up = 4'b0000;
    ack_dn = 1'b0;
    tick();
    chk("stale_done", busy, 0);

    // ---- reset in SEND for port 1 (pointer 1) ----
    req_up = 4'b0010;
    tick();
    chk("mid_gid", grant_id, 1);
    chk("mid_req_dn", req_dn, 1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_req_dn", req_dn, 0);
    chk("mid_rst_ack_up", ack_up, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_gid", grant_id, 0);
    chk("mid_rst_data", data_dn, 0);
    rst_n  = 1'b1;
    req_up = 4'b0011;
    tick();
    chk("mid_regrant_gid", grant_id, 0);
    chk("mid_regrant_req", req_dn, 1);
    ack_dn = 1'b1;
    tick();
    chk("mid_ack_up", ack_up, 4'b0001);
    req_up = 4'b0000;
    ack_dn = 1'b0;
    tick();
    chk("mid_done", ack_up, 0);

    // ---- protocol violation on port 3 (pointer 1) ----
    req_up = 4'b1000;
    tick();
    chk("vio_gid", grant_id, 3);
    chk("vio_data", data_dn, 4);
    req_up = 4'b0000;          // request withdrawn during SEND
    tick();
    chk("vio_req_hold", req_dn, 1);
    chk("vio_no_ack", ack_up, 0);
    ack_dn = 1'b1;
    tick();
    chk("vio_ack_pulse", ack_up, 4'b1000);
    chk("vio_req_dn_low", req_dn, 0);
    ack_dn = 1'b0;
    tick();
    chk("vio_ack_low", ack_up, 0);
    chk("vio_idle", busy, 0);
    req_up = 4'b0011;          // pointer must have wrapped to 0
    tick();
    chk("vio_ptr_wrap", grant_id, 0);
    ack_dn = 1'b1;
    tick();
    req_up = 4'b0000;
    ack_dn = 1'b0;
    tick();
    chk("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
